// File: rtl/mem_access_sequencer_pkg.sv
// rtl/mem_access_sequencer_pkg.sv - shared LC-3b types for the MEM-stage access sequencer
// Purpose: opcode, memory-operation kind and sequencer state enums, plus
//          small decode/classification helpers used by the sequencer files.
// Ports:   none (package).
package mem_access_sequencer_pkg;

  typedef enum logic [3:0] {
    op_br   = 4'd0,
    op_add  = 4'd1,
    op_ldb  = 4'd2,
    op_stb  = 4'd3,
    op_jsr  = 4'd4,
    op_and  = 4'd5,
    op_ldr  = 4'd6,
    op_str  = 4'd7,
    op_rti  = 4'd8,
    op_not  = 4'd9,
    op_ldi  = 4'd10,
    op_sti  = 4'd11,
    op_jmp  = 4'd12,
    op_shf  = 4'd13,
    op_lea  = 4'd14,
    op_trap = 4'd15
  } lc3b_opcode;

  typedef enum logic [2:0] {
    MEM_WORD_RD,
    MEM_BYTE_RD,
    MEM_IND_RD,
    MEM_WORD_WR,
    MEM_BYTE_WR,
    MEM_IND_WR
  } lc3b_memop_kind;

  typedef enum logic [1:0] {
    IDLE,
    PTR,
    ACCESS,
    COMPLETE
  } lc3b_mseq_state;

  // Opcodes with a dedicated memory form pick it directly; any other opcode
  // that reaches MEM with a memory request (e.g. TRAP vector fetch) is a
  // plain word access in the direction the control word asks for.
  function automatic lc3b_memop_kind decode_memop(input logic [3:0] opcode,
                                                  input logic       is_write);
    lc3b_memop_kind k;
    case (opcode)
      op_ldb:  k = MEM_BYTE_RD;
      op_ldi:  k = MEM_IND_RD;
      op_str:  k = MEM_WORD_WR;
      op_stb:  k = MEM_BYTE_WR;
      op_sti:  k = MEM_IND_WR;
      op_ldr:  k = MEM_WORD_RD;
      default: k = is_write ? MEM_WORD_WR : MEM_WORD_RD;
    endcase
    return k;
  endfunction

  function automatic logic is_read_kind(input lc3b_memop_kind k);
    return (k == MEM_WORD_RD) || (k == MEM_BYTE_RD) || (k == MEM_IND_RD);
  endfunction

  function automatic logic is_indirect_kind(input lc3b_memop_kind k);
    return (k == MEM_IND_RD) || (k == MEM_IND_WR);
  endfunction

  function automatic logic is_byte_kind(input lc3b_memop_kind k);
    return (k == MEM_BYTE_RD) || (k == MEM_BYTE_WR);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// rtl/mem_access_sequencer_if.sv - data-memory request/response bus
// Purpose: groups the data-memory handshake between the sequencer and memory.
// Ports:   mem_read/mem_write   request strobes (held until mem_resp)
//          mem_address          16-bit byte address
//          mem_wdata            write data
//          mem_byte_enable      byte lanes {hi, lo}
//          mem_resp             completion strobe from memory
//          mem_rdata            read data from memory
interface mem_access_sequencer_if;

  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    input  mem_resp,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    output mem_resp,
    output mem_rdata
  );

endinterface

// File: rtl/mem_access_sequencer_mem_byte_format.sv
// rtl/mem_access_sequencer_mem_byte_format.sv - byte-lane, write-data and load formatting
// Purpose: combinational formatting for the final access of an operation.
// Ports:   kind         latched operation kind
//          addr_lsb     bit 0 of the latched effective address
//          store_data   latched store source value
//          mem_rdata    raw memory read data
//          byte_enable  lanes for the access
//          wdata        write data with the byte replicated for byte stores
//          load_value   read data, byte-selected and sign-extended for LDB
module mem_byte_format
  import mem_access_sequencer_pkg::*;
(
  input  lc3b_memop_kind kind,
  input  logic           addr_lsb,
  input  logic [15:0]    store_data,
  input  logic [15:0]    mem_rdata,
  output logic [1:0]     byte_enable,
  output logic [15:0]    wdata,
  output logic [15:0]    load_value
);

  logic [7:0] sel_byte;

  always_comb begin
    byte_enable = 2'b11;
    wdata       = store_data;
    load_value  = mem_rdata;
    sel_byte    = addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0];

    if (is_byte_kind(kind)) begin
      byte_enable = addr_lsb ? 2'b10 : 2'b01;
    end
    // Byte stores replicate the low byte so either lane carries it.
    if (kind == MEM_BYTE_WR) begin
      wdata = {store_data[7:0], store_data[7:0]};
    end
    if (kind == MEM_BYTE_RD) begin
      load_value = {{8{sel_byte[7]}}, sel_byte};
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - MEM-stage data-memory access sequencer
// Purpose: turns the control word's memory fields into data-memory accesses
//          (word/byte, and pointer-then-access for LDI/STI), stalls the
//          pipeline until done, and returns formatted load data.
// Ports:   clk, reset_n                       clock, async active-low reset
//          in_valid, opcode                   MEM-stage instruction
//          ctrl_mem_read, ctrl_mem_write      control-word memory fields
//          addr, store_data                   effective address, store source
//          mem                                data-memory bus (master side)
//          load_data                          formatted result for writeback
//          stall, done                        pipeline hold, completion pulse
//          mem_error                          sticky response timeout flag
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [3:0]                    opcode,
  input  logic                          ctrl_mem_read,
  input  logic                          ctrl_mem_write,
  input  logic [15:0]                   addr,
  input  logic [15:0]                   store_data,
  mem_access_sequencer_if.master        mem,
  output logic [15:0]                   load_data,
  output logic                          stall,
  output logic                          done,
  output logic                          mem_error
);

  lc3b_mseq_state state, state_d;
  lc3b_memop_kind kind_q, new_kind;
  logic [15:0]    addr_q;
  logic [15:0]    sd_q;
  logic [15:1]    ptr_q;
  logic [31:0]    to_cnt;
  logic           memop;
  logic           access_is_read;
  logic [1:0]     fmt_be;
  logic [15:0]    fmt_wdata;
  logic [15:0]    fmt_load;

  assign memop          = in_valid & (ctrl_mem_read | ctrl_mem_write);
  assign new_kind       = decode_memop(opcode, ctrl_mem_write);
  assign access_is_read = is_read_kind(kind_q);

  mem_byte_format u_fmt (
    .kind        (kind_q),
    .addr_lsb    (addr_q[0]),
    .store_data  (sd_q),
    .mem_rdata   (mem.mem_rdata),
    .byte_enable (fmt_be),
    .wdata       (fmt_wdata),
    .load_value  (fmt_load)
  );

  always_comb begin
    state_d             = state;
    stall               = 1'b0;
    done                = 1'b0;
    mem.mem_read        = 1'b0;
    mem.mem_write       = 1'b0;
    mem.mem_address     = 16'h0000;
    mem.mem_wdata       = 16'h0000;
    mem.mem_byte_enable = 2'b00;

    case (state)
      IDLE: begin
        // Stall is combinational so the instruction is held from its first
        // MEM cycle, before any register has seen it.
        stall = memop;
        if (memop) begin
          state_d = is_indirect_kind(new_kind) ? PTR : ACCESS;
        end
      end
      PTR: begin
        stall               = 1'b1;
        mem.mem_read        = 1'b1;
        mem.mem_address     = {addr_q[15:1], 1'b0};
        mem.mem_byte_enable = 2'b11;
        if (mem.mem_resp) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall               = 1'b1;
        mem.mem_read        = access_is_read;
        mem.mem_write       = ~access_is_read;
        mem.mem_byte_enable = fmt_be;
        mem.mem_wdata       = fmt_wdata;
        if (is_indirect_kind(kind_q)) begin
          mem.mem_address = {ptr_q, 1'b0};
        end else if (is_byte_kind(kind_q)) begin
          mem.mem_address = addr_q;
        end else begin
          mem.mem_address = {addr_q[15:1], 1'b0};
        end
        if (mem.mem_resp) begin
          state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        // The finished instruction is still presented this cycle; in_valid
        // is deliberately not looked at so it is not started twice.
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kind_q    <= MEM_WORD_RD;
      addr_q    <= 16'h0000;
      sd_q      <= 16'h0000;
      ptr_q     <= 15'h0000;
      load_data <= 16'h0000;
      to_cnt    <= 32'd0;
      mem_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            kind_q <= new_kind;
            addr_q <= addr;
            sd_q   <= store_data;
            to_cnt <= 32'd0;
          end
        end
        PTR, ACCESS: begin
          if (mem.mem_resp) begin
            if (state == PTR) begin
              ptr_q  <= mem.mem_rdata[15:1];
              to_cnt <= 32'd0;
            end else if (access_is_read) begin
              load_data <= fmt_load;
            end
          end else begin
            // Counter saturates at the limit; with TIMEOUT_CYCLES == 0 it
            // never leaves zero and the flag can never set.
            if (to_cnt != TIMEOUT_CYCLES) begin
              to_cnt <= to_cnt + 32'd1;
            end
            if ((TIMEOUT_CYCLES != 0) && (to_cnt + 32'd1 == TIMEOUT_CYCLES)) begin
              mem_error <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- MEM-stage consumer of the decoded control word in the pipelined LC-3b datapath.
- Turns the control word's memory fields into a data-memory handshake: single word/byte accesses, and two-access indirect sequences for LDI/STI.
- Stalls the pipeline until the access completes.
- Returns formatted load data for writeback.

Parameters:
- TIMEOUT_CYCLES, 0, cycles to wait for mem_resp before raising mem_error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage holds a valid instruction
- opcode  in  4  lc3b_opcode of the MEM-stage instruction
- ctrl_mem_read  in  1  control-word mem_read
- ctrl_mem_write  in  1  control-word mem_write
- addr  in  16  effective address (EX alu result)
- store_data  in  16  source register value for stores
- mem_resp  in  1  memory completion strobe
- mem_rdata  in  16  memory read data
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_address  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_byte_enable  out  2  byte lanes
- load_data  out  16  formatted result for writeback
- stall  out  1  hold all upstream stages
- done  out  1  one-cycle completion pulse
- mem_error  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; all outputs 0; latched address, data and pointer registers 0; timeout counter 0.
- memop = in_valid & (ctrl_mem_read | ctrl_mem_write). Opcode selects the operation:
  - op_ldr and all other read opcodes (e.g. op_trap): word read.
  - op_ldb: byte read.
  - op_ldi: indirect read.
  - op_str: word write.
  - op_stb: byte write.
  - op_sti: indirect write.
- States:
  - IDLE: if memop, latch addr, store_data and the operation kind; go to PTR for LDI/STI, otherwise ACCESS.
  - PTR: mem_read=1, mem_address={a[15:1],0}, byte_enable=11. On mem_resp, latch ptr=mem_rdata and go to ACCESS.
  - ACCESS: drive the final access.
    - Address is ptr for indirect operations, else the latched address.
    - On mem_resp, latch load_data and go to COMPLETE.
  - COMPLETE: stall=0, done=1 for exactly one cycle; ignore in_valid (the same instruction is still present); go to IDLE.
- Word access: address LSB forced to 0, byte_enable=11, wdata=store_data.
- Byte write: byte_enable = a[0] ? 10 : 01; wdata = {sd[7:0], sd[7:0]}.
- Byte read: selected byte = a[0] ? rdata[15:8] : rdata[7:0], sign-extended to 16 bits.
- stall = (memop & state==IDLE) | state==PTR | state==ACCESS. Combinational, so the instruction is held from its first MEM cycle.
- Latency: a single access with memory responding on cycle k after issue gives done on k+1. An indirect access with responses r1 and r2 gives done one cycle after r2.
- mem_read and mem_write are never both 1. Each stays asserted, with address and data held stable, until mem_resp.
- mem_resp while in IDLE or COMPLETE is ignored.
- Inputs changing while in PTR or ACCESS have no effect (latched copies are used).
- load_data holds its value until the next completed read. Writes do not modify it.
- Timeout (TIMEOUT_CYCLES>0): a counter clears on entering PTR or ACCESS and increments each waiting cycle. Reaching TIMEOUT_CYCLES sets mem_error (sticky until reset); the state keeps waiting.
- Reset asserted mid-access: immediate return to IDLE with requests deasserted; the late response is ignored.

Decomposition:
- lc3b_types gains:
  - lc3b_memop_kind enum: MEM_WORD_RD, MEM_BYTE_RD, MEM_IND_RD, MEM_WORD_WR, MEM_BYTE_WR, MEM_IND_WR.
  - lc3b_mseq_state enum: IDLE, PTR, ACCESS, COMPLETE.
- One sub-module, mem_byte_format: combinational byte-lane/wdata generation and load sign extension. The FSM and counters stay in the top module.

Test Plan:
- LDR, addr=0x3001, memory returns 0xBEEF after 2 wait cycles -> mem_address=0x3000, byte_enable=11, stall for 3 cycles, then done=1 with load_data=0xBEEF.
- LDB, addr=0x4001, rdata=0x80FF -> load_data=0xFF80; LDB with addr=0x4000 -> 0xFFFF.
- STB, addr=0x5001, store_data=0x1234 -> mem_write=1, byte_enable=10, wdata=0x3434, done one cycle after resp, load_data unchanged.
- LDI, addr=0x6000, mem[0x6000]=0x7002, mem[0x7002]=0x00AA -> two reads (0x6000 then 0x7002), load_data=0x00AA, stall continuous until COMPLETE.
- STI, addr=0x6000, ptr=0x7004, store_data=0x5555 -> read 0x6000, then write 0x7004 with wdata=0x5555, byte_enable=11.
- TIMEOUT_CYCLES=4, no mem_resp -> mem_error=1 after 4 waiting cycles and stays high. Pull reset_n low mid-ACCESS -> mem_read=0 immediately, state IDLE; a subsequent stray mem_resp yields no done.
